detonator_arm_sequencer: RTL and testbench
==========================================

DETONATOR_ARM_SEQUENCER -- requirements
Module: detonator_arm_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 4, clock cycles per countdown step (minimum 1).
REQ-002 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port A  in  10  keypad, one-hot, bit n = digit n.
REQ-005 SHALL have port setup  in  1  request code programming.
REQ-006 SHALL have port ready  in  1  request code entry for arming.
REQ-007 SHALL have port sure  in  1  confirm entered digits.
REQ-008 SHALL have port fire  in  1  start countdown when armed.
REQ-009 SHALL have port wait_t  in  1  abort or step back.
REQ-010 SHALL have port m_disp  out  4  displayed digit, BCD 0-9.
REQ-011 SHALL have port digit_cnt  out  3  digits held in entry buffer, 0-4.
REQ-012 SHALL have ports armed, fired, locked  out  1 each  state flags; err  out  1  one-cycle error pulse.

Function
REQ-013 SHALL have states IDLE, SETUP, ENTRY, ARMED, COUNT, FIRED, LOCK, one-hot or binary encoded.
REQ-014 SHALL accept a key only in the cycle after A goes from all-zero to exactly one bit set; multi-bit or held values SHALL be ignored until A returns to zero.
REQ-015 SHALL shift each accepted key into a 4-digit BCD buffer and increment digit_cnt; keys after the 4th SHALL be ignored.
REQ-016 Input priority per cycle SHALL be wait_t > sure > setup/ready/fire > key.
REQ-017 IDLE: setup -> SETUP; ready -> ENTRY only if a code is stored, else err pulse and stay in IDLE; the buffer SHALL clear on entry to SETUP or ENTRY.
REQ-018 SETUP: sure with digit_cnt=4 SHALL store the buffer as the code, set code_valid, and go to IDLE; sure with digit_cnt<4 SHALL pulse err and keep the digits; wait_t -> IDLE with the stored code unchanged.
REQ-019 ENTRY: sure with digit_cnt=4 and match -> ARMED and clear fail count; mismatch SHALL pulse err, clear the buffer, and increment fail count; sure with digit_cnt<4 SHALL pulse err only; wait_t -> IDLE.
REQ-020 ARMED: armed=1; fire -> COUNT with counter=9 and tick counter=0; wait_t -> IDLE.
REQ-021 COUNT: counter SHALL decrement once every TICK_CYCLES cycles; wait_t -> ARMED; the step that would decrement from 0 SHALL go to FIRED instead.
REQ-022 FIRED: fired=1 held; all inputs except rst SHALL be ignored.
REQ-023 m_disp SHALL show the last accepted digit in SETUP/ENTRY (0 if none), the counter in COUNT, 9 in FIRED, and 0 otherwise.
REQ-024 err SHALL be high for exactly one cycle per error event and never in the same cycle as a state change to ARMED.

Reset
REQ-025 rst SHALL put the block in IDLE, clear code_valid, the stored code, the buffer, the fail count, and both counters, and drive every output to 0; this applies in any state, including mid-COUNT.

Configuration
REQ-026 Macro LOCKOUT_EN defined: the 3rd consecutive mismatch SHALL go to LOCK with locked=1, where only rst exits. Macro undefined: mismatches never lock, locked is tied to 0, and the fail count SHALL saturate at 3.

Verification
REQ-027 Program code: setup, keys 2,5,8,1, then sure -> IDLE, code_valid=1, digit_cnt=0.
REQ-028 Arm and fire with TICK_CYCLES=4: ready, keys 2,5,8,1, then sure -> armed=1; fire -> m_disp counts 9..0, with fired=1 exactly 40 cycles after COUNT entry.
REQ-029 Wrong code: ready, keys 2,5,8,0, then sure -> err pulse, digit_cnt=0, state stays ENTRY; with LOCKOUT_EN, three mismatches -> locked=1 and ready is ignored.
REQ-030 Key rules: A=0x024 (two bits set) is ignored; A held at 0x004 for 5 cycles counts once; a 5th key leaves digit_cnt=4.
REQ-031 Abort and reset: wait_t during COUNT -> ARMED with m_disp=0; rst asserted at counter=5 -> IDLE with all outputs 0 on the next edge and code_valid=0.

Source files
------------

// File: rtl/detonator_arm_sequencer.sv
// Code-protected arm/fire sequencer with a 9..0 countdown.
// Optional lockout after three consecutive wrong codes: define LOCKOUT_EN.
module detonator_arm_sequencer #(
  parameter int unsigned TICK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] A,
  input  logic       setup,
  input  logic       ready,
  input  logic       sure,
  input  logic       fire,
  input  logic       wait_t,
  output logic [3:0] m_disp,
  output logic [2:0] digit_cnt,
  output logic       armed,
  output logic       fired,
  output logic       locked,
  output logic       err
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, ENTRY, ARMED, COUNT, FIRED, LOCK} state_t;

  state_t      state_q, state_d;
  logic [9:0]  a_q, a_prev_q;
  logic [15:0] buf_q, buf_d, code_q, code_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        code_valid_q, code_valid_d;
  logic [1:0]  fail_q, fail_d;
  logic [3:0]  ctr_q, ctr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]  m_disp_q, m_disp_d;
  logic        err_q, err_d, armed_q, fired_q;
  logic        key_hit;
  logic [3:0]  key_digit;

  // A key is a zero-to-one-hot transition, seen one cycle late through a_q.
  assign key_hit = (a_prev_q == 10'd0) && $onehot(a_q) && !(setup || ready || fire);

  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (a_q[i]) key_digit = 4'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    fail_d       = fail_q;
    ctr_d        = ctr_q;
    tick_d       = tick_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (wait_t || sure) begin
        end else if (setup) begin
          state_d = SETUP;
          buf_d   = 16'd0;
          cnt_d   = 3'd0;
        end else if (ready) begin
          if (code_valid_q) begin
            state_d = ENTRY;
            buf_d   = 16'd0;
            cnt_d   = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP, ENTRY: begin
        if (wait_t) begin
          state_d = IDLE;
          buf_d   = 16'd0;
          cnt_d   = 3'd0;
        end else if (sure) begin
          if (cnt_q != 3'd4) begin
            err_d = 1'b1;
          end else if (state_q == SETUP) begin
            code_d       = buf_q;
            code_valid_d = 1'b1;
            state_d      = IDLE;
            buf_d        = 16'd0;
            cnt_d        = 3'd0;
          end else if (buf_q == code_q) begin
            state_d = ARMED;
            fail_d  = 2'd0;
            buf_d   = 16'd0;
            cnt_d   = 3'd0;
          end else begin
            err_d = 1'b1;
            buf_d = 16'd0;
            cnt_d = 3'd0;
`ifdef LOCKOUT_EN
            if (fail_q == 2'd2) state_d = LOCK;
            fail_d = fail_q + 2'd1;
`else
            if (fail_q != 2'd3) fail_d = fail_q + 2'd1;
`endif
          end
        end else if (key_hit && cnt_q < 3'd4) begin
          buf_d = {buf_q[11:0], key_digit};
          cnt_d = cnt_q + 3'd1;
        end
      end
      ARMED: begin
        if (wait_t) begin
          state_d = IDLE;
        end else if (fire) begin
          state_d = COUNT;
          ctr_d   = 4'd9;
          tick_d  = '0;
        end
      end
      COUNT: begin
        if (wait_t) begin
          state_d = ARMED;
        end else if (tick_q == TW'(TICK_CYCLES - 1)) begin
          tick_d = '0;
          if (ctr_q == 4'd0) state_d = FIRED;
          else               ctr_d   = ctr_q - 4'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      FIRED, LOCK: begin
      end
      default: state_d = IDLE;
    endcase

    // Display follows the next state so it lines up with the state flags.
    case (state_d)
      SETUP, ENTRY: m_disp_d = buf_d[3:0];
      COUNT:        m_disp_d = ctr_d;
      FIRED:        m_disp_d = 4'd9;
      default:      m_disp_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= 10'd0;
      a_prev_q     <= 10'd0;
      buf_q        <= 16'd0;
      cnt_q        <= 3'd0;
      code_q       <= 16'd0;
      code_valid_q <= 1'b0;
      fail_q       <= 2'd0;
      ctr_q        <= 4'd0;
      tick_q       <= '0;
      m_disp_q     <= 4'd0;
      err_q        <= 1'b0;
      armed_q      <= 1'b0;
      fired_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= A;
      a_prev_q     <= a_q;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      fail_q       <= fail_d;
      ctr_q        <= ctr_d;
      tick_q       <= tick_d;
      m_disp_q     <= m_disp_d;
      err_q        <= err_d;
      armed_q      <= (state_d == ARMED);
      fired_q      <= (state_d == FIRED);
    end
  end

`ifdef LOCKOUT_EN
  logic locked_q;
  always_ff @(posedge clk) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= (state_d == LOCK);
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign m_disp    = m_disp_q;
  assign digit_cnt = cnt_q;
  assign armed     = armed_q;
  assign fired     = fired_q;
  assign err       = err_q;

endmodule

// File: tb/tb_detonator_arm_sequencer.sv
// Directed bench: vector table for programming/entry, hand sequences for countdown, abort, reset, lockout.
module tb_detonator_arm_sequencer;

  logic       clk = 1'b0;
  logic       rst, setup, ready, sure, fire, wait_t;
  logic [9:0] A;
  logic [3:0] m_disp;
  logic [2:0] digit_cnt;
  logic       armed, fired, locked, err;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  detonator_arm_sequencer #(.TICK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .A(A), .setup(setup), .ready(ready), .sure(sure),
    .fire(fire), .wait_t(wait_t), .m_disp(m_disp), .digit_cnt(digit_cnt),
    .armed(armed), .fired(fired), .locked(locked), .err(err)
  );

  typedef struct {
    logic       su, rd, sr, fi, wt;
    logic [9:0] a;
    logic [3:0] disp;
    logic [2:0] cnt;
    logic       arm, fir, er;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic su, logic rd, logic sr, logic fi, logic wt, logic [9:0] a,
                              logic [3:0] disp, logic [2:0] cnt, logic arm, logic fir, logic er);
    vec_t v;
    v.su = su; v.rd = rd; v.sr = sr; v.fi = fi; v.wt = wt; v.a = a;
    v.disp = disp; v.cnt = cnt; v.arm = arm; v.fir = fir; v.er = er;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    setup = 0; ready = 0; sure = 0; fire = 0; wait_t = 0; A = 10'd0;
  endtask

  task automatic press(int d);
    A = 10'b1 << d;
    tick();
    A = 10'd0;
    tick();
  endtask

  task automatic all_zero(string name);
    chk({name, ".m_disp"}, 16'(m_disp), 16'd0);
    chk({name, ".digit_cnt"}, 16'(digit_cnt), 16'd0);
    chk({name, ".armed"}, 16'(armed), 16'd0);
    chk({name, ".fired"}, 16'(fired), 16'd0);
    chk({name, ".locked"}, 16'(locked), 16'd0);
    chk({name, ".err"}, 16'(err), 16'd0);
  endtask

  task automatic program_code();
    setup = 1; tick(); setup = 0;
    press(2); press(5); press(8); press(1);
    sure = 1; tick(); sure = 0;
  endtask

  task automatic arm_and_fire();
    ready = 1; tick(); ready = 0;
    press(2); press(5); press(8); press(1);
    sure = 1; tick(); sure = 0;
    chk("arm.armed", 16'(armed), 16'd1);
    fire = 1; tick(); fire = 0;
    chk("fire.m_disp", 16'(m_disp), 16'd9);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    all_zero("reset");

    //   su rd sr fi wt  A        disp cnt arm fir err
    add(0, 1, 0, 0, 0, 10'h000, 0, 0, 0, 0, 1);  // ready with no code stored
    add(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);  // SETUP
    add(0, 0, 0, 0, 0, 10'h004, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h020, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 5, 2, 0, 0, 0);
    add(0, 0, 1, 0, 0, 10'h000, 5, 2, 0, 0, 1);  // sure with 2 digits
    add(0, 0, 0, 0, 0, 10'h100, 5, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 8, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h002, 8, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 1, 4, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h008, 1, 4, 0, 0, 0);  // 5th key ignored
    add(0, 0, 0, 0, 0, 10'h000, 1, 4, 0, 0, 0);
    add(0, 0, 1, 0, 0, 10'h000, 0, 0, 0, 0, 0);  // store code -> IDLE
    add(0, 1, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);  // ENTRY
    add(0, 0, 0, 0, 0, 10'h004, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h020, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 5, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h100, 5, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 8, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h001, 8, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 0, 4, 0, 0, 0);
    add(0, 0, 1, 0, 0, 10'h000, 0, 0, 0, 0, 1);  // mismatch
    add(0, 0, 0, 0, 0, 10'h024, 0, 0, 0, 0, 0);  // two bits set
    add(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h004, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h020, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 5, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h100, 5, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 8, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h002, 8, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 1, 4, 0, 0, 0);
    add(0, 0, 1, 0, 0, 10'h000, 0, 0, 1, 0, 0);  // match -> ARMED
    add(0, 0, 0, 1, 0, 10'h000, 9, 0, 0, 0, 0);  // fire -> COUNT

    for (int i = 0; i < vq.size(); i++) begin
      setup = vq[i].su; ready = vq[i].rd; sure = vq[i].sr;
      fire = vq[i].fi; wait_t = vq[i].wt; A = vq[i].a;
      tick();
      chk($sformatf("vec%0d.m_disp", i), 16'(m_disp), 16'(vq[i].disp));
      chk($sformatf("vec%0d.digit_cnt", i), 16'(digit_cnt), 16'(vq[i].cnt));
      chk($sformatf("vec%0d.armed", i), 16'(armed), 16'(vq[i].arm));
      chk($sformatf("vec%0d.fired", i), 16'(fired), 16'(vq[i].fir));
      chk($sformatf("vec%0d.err", i), 16'(err), 16'(vq[i].er));
    end
    idle_inputs();

    // Countdown: fired exactly 40 cycles after COUNT entry.
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i < 40) begin
        chk($sformatf("count%0d.m_disp", i), 16'(m_disp), 16'(9 - i / 4));
        chk($sformatf("count%0d.fired", i), 16'(fired), 16'd0);
      end else begin
        chk("count40.fired", 16'(fired), 16'd1);
        chk("count40.m_disp", 16'(m_disp), 16'd9);
      end
    end
    wait_t = 1; ready = 1; setup = 1; A = 10'h004; tick(); tick(); idle_inputs(); tick();
    chk("fired_hold.fired", 16'(fired), 16'd1);
    chk("fired_hold.digit_cnt", 16'(digit_cnt), 16'd0);

    // Reset out of FIRED, then abort and mid-count reset.
    rst = 1; tick(); rst = 0;
    all_zero("rst_fired");
    ready = 1; tick(); ready = 0;
    chk("no_code.err", 16'(err), 16'd1);
    tick();
    chk("err_one_cycle", 16'(err), 16'd0);
    program_code();
    chk("prog.digit_cnt", 16'(digit_cnt), 16'd0);
    arm_and_fire();
    for (int i = 0; i < 16; i++) tick();
    chk("abort_pre.m_disp", 16'(m_disp), 16'd5);
    wait_t = 1; tick(); wait_t = 0;
    chk("abort.m_disp", 16'(m_disp), 16'd0);
    chk("abort.armed", 16'(armed), 16'd1);
    fire = 1; tick(); fire = 0;
    chk("refire.m_disp", 16'(m_disp), 16'd9);
    for (int i = 0; i < 16; i++) tick();
    chk("rst_pre.m_disp", 16'(m_disp), 16'd5);
    rst = 1; tick(); rst = 0;
    all_zero("rst_count");
    ready = 1; tick(); ready = 0;
    chk("rst_code_cleared.err", 16'(err), 16'd1);

    // Three consecutive mismatches.
    tick();
    program_code();
    ready = 1; tick(); ready = 0;
    for (int k = 0; k < 3; k++) begin
      press(2); press(5); press(8); press(0);
      sure = 1; tick(); sure = 0;
      chk($sformatf("miss%0d.err", k), 16'(err), 16'd1);
      chk($sformatf("miss%0d.digit_cnt", k), 16'(digit_cnt), 16'd0);
    end
`ifdef LOCKOUT_EN
    chk("lock.locked", 16'(locked), 16'd1);
    ready = 1; tick(); ready = 0; tick();
    chk("lock_ready.locked", 16'(locked), 16'd1);
    chk("lock_ready.err", 16'(err), 16'd0);
    press(2);
    chk("lock_key.digit_cnt", 16'(digit_cnt), 16'd0);
`else
    chk("nolock.locked", 16'(locked), 16'd0);
    press(2); press(5); press(8); press(1);
    sure = 1; tick(); sure = 0;
    chk("nolock_arm.armed", 16'(armed), 16'd1);
    chk("nolock_arm.err", 16'(err), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
